// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - shared types for the SoC memory-port arbiter
package soc_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_WAIT_IFU = 2'd1,
        ARB_WAIT_LSU = 2'd2
    } arb_state;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner;

    localparam int STATE_STR_CHARS = 12;

    // Fixed-width ASCII name of an arbiter state, for waveform debug
    function automatic logic [8*STATE_STR_CHARS-1:0] arb_state_name(input arb_state s);
        case (s)
            ARB_IDLE:     return "ARB_IDLE    ";
            ARB_WAIT_IFU: return "ARB_WAIT_IFU";
            ARB_WAIT_LSU: return "ARB_WAIT_LSU";
            default:      return "ARB_INVALID ";
        endcase
    endfunction

endpackage

// File: rtl/arb_req_slot.sv
// rtl/arb_req_slot.sv - one-entry holding register for a deferred request
module arb_req_slot #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] data
);

    // Capture a request when told to; drop the valid bit once it has been issued
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load && !valid) begin
            valid <= 1'b1;
            data  <= din;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between fetch and load/store units
module mem_arbiter
    import soc_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter bit LSU_FIRST = 1'b1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           ifu_reqValid,
    input  logic [AW-1:0]                  ifu_addr,
    output logic                           ifu_respValid,
    output logic [DW-1:0]                  ifu_rdata,
    input  logic                           lsu_reqValid,
    input  logic [AW-1:0]                  lsu_addr,
    input  logic                           lsu_wen,
    input  logic [DW-1:0]                  lsu_wdata,
    input  logic [DW/8-1:0]                lsu_wmask,
    output logic                           lsu_respValid,
    output logic [DW-1:0]                  lsu_rdata,
    output logic                           mem_reqValid,
    output logic [AW-1:0]                  mem_addr,
    output logic                           mem_wen,
    output logic [DW-1:0]                  mem_wdata,
    output logic [DW/8-1:0]                mem_wmask,
    input  logic                           mem_respValid,
    input  logic [DW-1:0]                  mem_rdata,
    output logic                           dbg_stray_err,
    output logic [8*STATE_STR_CHARS-1:0]   dbg_state_str
);

    localparam int MW = DW / 8;
    localparam int LW = AW + 1 + DW + MW;
    localparam arb_owner RR_INIT = LSU_FIRST ? OWN_LSU : OWN_IFU;

    arb_state state, state_nxt;
    arb_owner rr, rr_nxt;

    logic          ifu_slot_valid;
    logic [AW-1:0] ifu_slot_addr;
    logic          lsu_slot_valid;
    logic [LW-1:0] lsu_slot_data;
    logic [LW-1:0] lsu_live;

    logic [AW-1:0] ifu_src_addr;
    logic [AW-1:0] lsu_src_addr;
    logic          lsu_src_wen;
    logic [DW-1:0] lsu_src_wdata;
    logic [MW-1:0] lsu_src_wmask;

    logic ifu_cand, lsu_cand;
    logic grant_ifu, grant_lsu;
    logic ifu_resp, lsu_resp, stray_resp;

    logic [AW-1:0] iss_addr;
    logic [DW-1:0] iss_wdata;
    logic [MW-1:0] iss_wmask;
    logic [DW-1:0] ifu_rdata_q;
    logic [DW-1:0] lsu_rdata_q;
    logic          stray_err_q;

    assign lsu_live = {lsu_addr, lsu_wen, lsu_wdata, lsu_wmask};

    // A pending slot takes precedence over a live pulse; a pulse on top of a full slot is dropped
    assign ifu_cand     = ifu_slot_valid | ifu_reqValid;
    assign lsu_cand     = lsu_slot_valid | lsu_reqValid;
    assign ifu_src_addr = ifu_slot_valid ? ifu_slot_addr : ifu_addr;
    assign {lsu_src_addr, lsu_src_wen, lsu_src_wdata, lsu_src_wmask} =
        lsu_slot_valid ? lsu_slot_data : lsu_live;

    arb_req_slot #(.W(AW)) u_ifu_slot (
        .clock (clock),
        .reset (reset),
        .load  (ifu_reqValid && !grant_ifu),
        .clear (grant_ifu),
        .din   (ifu_addr),
        .valid (ifu_slot_valid),
        .data  (ifu_slot_addr)
    );

    arb_req_slot #(.W(LW)) u_lsu_slot (
        .clock (clock),
        .reset (reset),
        .load  (lsu_reqValid && !grant_lsu),
        .clear (grant_lsu),
        .din   (lsu_live),
        .valid (lsu_slot_valid),
        .data  (lsu_slot_data)
    );

    // Grant selection, response routing and next-state decode
    always_comb begin
        grant_ifu  = 1'b0;
        grant_lsu  = 1'b0;
        rr_nxt     = rr;
        state_nxt  = state;
        ifu_resp   = 1'b0;
        lsu_resp   = 1'b0;
        stray_resp = 1'b0;
        case (state)
            ARB_IDLE: begin
                // No grant may leak out while reset is held, even for a live pulse
                if (reset) begin
                    if (ifu_cand && lsu_cand) begin
                        grant_lsu = (rr == OWN_LSU);
                        grant_ifu = (rr == OWN_IFU);
                        rr_nxt    = (rr == OWN_LSU) ? OWN_IFU : OWN_LSU;
                    end else begin
                        grant_ifu = ifu_cand;
                        grant_lsu = lsu_cand;
                    end
                end
                if (grant_ifu) begin
                    if (mem_respValid) ifu_resp = 1'b1;
                    else               state_nxt = ARB_WAIT_IFU;
                end else if (grant_lsu) begin
                    if (mem_respValid) lsu_resp = 1'b1;
                    else               state_nxt = ARB_WAIT_LSU;
                end else if (mem_respValid) begin
                    stray_resp = 1'b1;
                end
            end
            ARB_WAIT_IFU: begin
                if (mem_respValid) begin
                    ifu_resp  = 1'b1;
                    state_nxt = ARB_IDLE;
                end
            end
            ARB_WAIT_LSU: begin
                if (mem_respValid) begin
                    lsu_resp  = 1'b1;
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // State and round-robin pointer registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ARB_IDLE;
            rr    <= RR_INIT;
        end else begin
            state <= state_nxt;
            rr    <= rr_nxt;
        end
    end

    // Remember the issued request so the port keeps showing the owner's address while waiting
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            iss_addr  <= '0;
            iss_wdata <= '0;
            iss_wmask <= '0;
        end else if (grant_lsu) begin
            iss_addr  <= lsu_src_addr;
            iss_wdata <= lsu_src_wdata;
            iss_wmask <= lsu_src_wmask;
        end else if (grant_ifu) begin
            iss_addr  <= ifu_src_addr;
            iss_wdata <= '0;
            iss_wmask <= '0;
        end
    end

    // Per-requester read data holds its last value between responses; stray responses stick
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
            stray_err_q <= 1'b0;
        end else begin
            if (ifu_resp)   ifu_rdata_q <= mem_rdata;
            if (lsu_resp)   lsu_rdata_q <= mem_rdata;
            if (stray_resp) stray_err_q <= 1'b1;
        end
    end

    assign mem_reqValid  = grant_ifu | grant_lsu;
    assign mem_addr      = grant_lsu ? lsu_src_addr  : (grant_ifu ? ifu_src_addr : iss_addr);
    assign mem_wen       = grant_lsu & lsu_src_wen;
    assign mem_wdata     = grant_lsu ? lsu_src_wdata : (grant_ifu ? '0 : iss_wdata);
    assign mem_wmask     = grant_lsu ? lsu_src_wmask : (grant_ifu ? '0 : iss_wmask);

    assign ifu_respValid = ifu_resp;
    assign lsu_respValid = lsu_resp;
    assign ifu_rdata     = ifu_resp ? mem_rdata : ifu_rdata_q;
    assign lsu_rdata     = lsu_resp ? mem_rdata : lsu_rdata_q;
    assign dbg_stray_err = stray_err_q;

    assign dbg_state_str = arb_state_name(state);

    ifu_slot_overrun: assert property (@(posedge clock) disable iff (!reset)
        !(ifu_reqValid && ifu_slot_valid));
    lsu_slot_overrun: assert property (@(posedge clock) disable iff (!reset)
        !(lsu_reqValid && lsu_slot_valid));

endmodule
